// File: rtl/hazard_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hazard_pkg : shared types and default widths for the branch hazard unit
// Revision   : 1.0
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int HZ_REG_ADDR_W = 4;
    localparam int HZ_CNT_W      = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        PC_WAIT = 1'b1
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sat_counter : event counter that sticks at all-ones instead of wrapping
// Revision    : 1.0
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// branch_hazard_ctrl : stall/flush/forwarding control with PC-write wait FSM
// Revision           : 1.0
// ----------------------------------------------------------------------------
module branch_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = HZ_REG_ADDR_W,
    parameter int CNT_W      = HZ_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_taken,
    input  logic                  pc_src_d,
    input  logic                  pc_src_w,
    input  logic                  mem_to_reg_e,
    input  logic [REG_ADDR_W-1:0] ra1_d,
    input  logic [REG_ADDR_W-1:0] ra2_d,
    input  logic [REG_ADDR_W-1:0] ra1_e,
    input  logic [REG_ADDR_W-1:0] ra2_e,
    input  logic [REG_ADDR_W-1:0] wa3_e,
    input  logic [REG_ADDR_W-1:0] wa3_m,
    input  logic [REG_ADDR_W-1:0] wa3_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic [CNT_W-1:0]      branch_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [REG_ADDR_W-1:0] PC_ADDR = {REG_ADDR_W{1'b1}};

    hz_state_t  state_q, state_d;
    logic [1:0] wd_q, wd_d;
    logic       lu_stall;

    // The PC register reads as PC+8 in Execute, so it is never a forwarding target.
    function automatic fwd_sel_t fwd_pick(
        input logic [REG_ADDR_W-1:0] ra,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] wa_m,
        input logic                  we_w,
        input logic [REG_ADDR_W-1:0] wa_w
    );
        if (ra == PC_ADDR)              return FWD_RF;
        if (we_m && (wa_m == ra))       return FWD_MEM;
        if (we_w && (wa_w == ra))       return FWD_WB;
        return FWD_RF;
    endfunction

    always_comb begin
        forward_a_e = fwd_pick(ra1_e, reg_write_m, wa3_m, reg_write_w, wa3_w);
        forward_b_e = fwd_pick(ra2_e, reg_write_m, wa3_m, reg_write_w, wa3_w);
    end

    assign lu_stall = mem_to_reg_e && (wa3_e != '0) &&
                      ((wa3_e == ra1_d) || (wa3_e == ra2_d));

    // A taken branch squashes everything younger, so it overrides any stall.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (reset) begin
            if (branch_taken) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else begin
                if (lu_stall) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
                if (state_q == PC_WAIT) begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        case (state_q)
            RUN: begin
                wd_d = 2'd0;
                if (pc_src_d && !lu_stall && !branch_taken) begin
                    state_d = PC_WAIT;
                end
            end
            PC_WAIT: begin
                if (pc_src_w || branch_taken || (wd_q == 2'd2)) begin
                    state_d = RUN;
                    wd_d    = 2'd0;
                end else begin
                    wd_d = wd_q + 2'd1;
                end
            end
            default: begin
                state_d = RUN;
                wd_d    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            wd_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_taken),
        .count (branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_d | flush_e),
        .count (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_d),
        .count (stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_branch_hazard_ctrl : directed bench for branch_hazard_ctrl (16- and 4-bit counters)
// Revision              : 1.0
// ----------------------------------------------------------------------------
module tb_branch_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       branch_taken, pc_src_d, pc_src_w, mem_to_reg_e;
    logic [3:0] ra1_d, ra2_d, ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    logic       reg_write_m, reg_write_w;

    logic        stall_f, stall_d, flush_d, flush_e;
    logic [1:0]  forward_a_e, forward_b_e;
    logic [15:0] branch_cnt, flush_cnt, stall_cnt;

    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
    logic [1:0]  s_forward_a_e, s_forward_b_e;
    logic [3:0]  s_branch_cnt, s_flush_cnt, s_stall_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .pc_src_d(pc_src_d),
        .pc_src_w(pc_src_w), .mem_to_reg_e(mem_to_reg_e), .ra1_d(ra1_d), .ra2_d(ra2_d),
        .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e), .wa3_m(wa3_m), .wa3_w(wa3_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .stall_f(stall_f),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e), .forward_a_e(forward_a_e),
        .forward_b_e(forward_b_e), .branch_cnt(branch_cnt), .flush_cnt(flush_cnt),
        .stall_cnt(stall_cnt)
    );

    branch_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .branch_taken(branch_taken), .pc_src_d(pc_src_d),
        .pc_src_w(pc_src_w), .mem_to_reg_e(mem_to_reg_e), .ra1_d(ra1_d), .ra2_d(ra2_d),
        .ra1_e(ra1_e), .ra2_e(ra2_e), .wa3_e(wa3_e), .wa3_m(wa3_m), .wa3_w(wa3_w),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .stall_f(s_stall_f),
        .stall_d(s_stall_d), .flush_d(s_flush_d), .flush_e(s_flush_e),
        .forward_a_e(s_forward_a_e), .forward_b_e(s_forward_b_e),
        .branch_cnt(s_branch_cnt), .flush_cnt(s_flush_cnt), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic clr();
        branch_taken = 0; pc_src_d = 0; pc_src_w = 0; mem_to_reg_e = 0;
        ra1_d = 0; ra2_d = 0; ra1_e = 0; ra2_e = 0;
        wa3_e = 0; wa3_m = 0; wa3_w = 0; reg_write_m = 0; reg_write_w = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Checks {stall_f, stall_d, flush_d, flush_e} after the inputs settle.
    task automatic ctl(input string tag, input logic [3:0] exp);
        #1;
        check(tag, {28'd0, stall_f, stall_d, flush_d, flush_e}, {28'd0, exp});
    endtask

    task automatic cnts(input string tag, input int b, input int f, input int s);
        check({tag, "_branch"}, {16'd0, branch_cnt}, b[31:0]);
        check({tag, "_flush"},  {16'd0, flush_cnt},  f[31:0]);
        check({tag, "_stall"},  {16'd0, stall_cnt},  s[31:0]);
    endtask

    initial begin
        clr();
        reset = 1'b0;
        // Active reset: control forced low, forwarding still live.
        mem_to_reg_e = 1; wa3_e = 3; ra1_d = 3;
        reg_write_m = 1; wa3_m = 5; ra1_e = 5;
        #12;
        ctl("rst_ctl", 4'b0000);
        check("rst_fwd_a", {30'd0, forward_a_e}, 32'd2);
        cnts("rst", 0, 0, 0);
        clr();
        reset = 1'b1;
        step();

        // Load-use stall on ra1_d
        clr(); mem_to_reg_e = 1; wa3_e = 3; ra1_d = 3;
        ctl("lu_ra1", 4'b1101);
        step(); clr();
        cnts("lu_after", 0, 1, 1);
        mem_to_reg_e = 1; wa3_e = 0; ra1_d = 0;
        ctl("lu_r0", 4'b0000);
        step(); clr();
        cnts("lu_r0_after", 0, 1, 1);

        // PC write: three wait cycles, pc_src_w on the third
        pc_src_d = 1;
        ctl("pcw_run", 4'b0000);
        step(); clr();
        ctl("pcw_c1", 4'b1010);
        step();
        ctl("pcw_c2", 4'b1010);
        step(); pc_src_w = 1;
        ctl("pcw_c3", 4'b1010);
        step(); clr();
        ctl("pcw_done", 4'b0000);
        cnts("pcw", 0, 4, 1);

        // Watchdog release with no pc_src_w
        pc_src_d = 1;
        step(); clr();
        step(); step();
        ctl("wd_c3", 4'b1010);
        step();
        ctl("wd_exit", 4'b0000);
        check("wd_fcnt", {16'd0, flush_cnt}, 32'd7);

        // Taken branch squashes the wait, pc_src_d alongside is ignored
        pc_src_d = 1;
        step(); clr();
        ctl("bt_wait", 4'b1010);
        step(); branch_taken = 1; pc_src_d = 1;
        ctl("bt_in_wait", 4'b0011);
        step(); clr();
        ctl("bt_exit", 4'b0000);
        cnts("bt", 1, 9, 1);

        // Branch overrides load-use on ra2_d
        branch_taken = 1; mem_to_reg_e = 1; wa3_e = 2; ra2_d = 2;
        ctl("bt_lu", 4'b0011);
        step(); clr();
        cnts("bt_lu", 2, 10, 1);

        // Forwarding
        reg_write_m = 1; wa3_m = 5; reg_write_w = 1; wa3_w = 5; ra1_e = 5; ra2_e = 0;
        #1;
        check("fwd_mem_pri", {30'd0, forward_a_e}, 32'd2);
        check("fwd_b_none", {30'd0, forward_b_e}, 32'd0);
        wa3_m = 15; wa3_w = 15; ra1_e = 15;
        #1;
        check("fwd_pc", {30'd0, forward_a_e}, 32'd0);
        reg_write_m = 1; wa3_m = 6; reg_write_w = 1; wa3_w = 7; ra1_e = 7; ra2_e = 6;
        #1;
        check("fwd_a_wb", {30'd0, forward_a_e}, 32'd1);
        check("fwd_b_mem", {30'd0, forward_b_e}, 32'd2);
        reg_write_w = 0;
        #1;
        check("fwd_a_nowe", {30'd0, forward_a_e}, 32'd0);
        clr();

        // 20 taken branches: 4-bit counters pin at 15
        branch_taken = 1;
        for (int i = 0; i < 20; i++) step();
        clr(); #1;
        cnts("sat", 22, 30, 1);
        check("sat_small_branch", {28'd0, s_branch_cnt}, 32'd15);
        check("sat_small_flush",  {28'd0, s_flush_cnt},  32'd15);
        check("sat_small_stall",  {28'd0, s_stall_cnt},  32'd1);

        // Reset in the middle of a PC wait
        pc_src_d = 1;
        step(); clr();
        ctl("mid_wait", 4'b1010);
        reset = 1'b0;
        ctl("mid_rst", 4'b0000);
        cnts("mid_rst", 0, 0, 0);
        check("mid_rst_small", {28'd0, s_branch_cnt}, 32'd0);
        step();
        reset = 1'b1;
        ctl("post_rst", 4'b0000);
        step();
        ctl("post_rst2", 4'b0000);
        cnts("post_rst", 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_hazard_ctrl.md
BRANCH_HAZARD_CTRL -- requirements
Module: branch_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, event-counter width.
REQ-003 SHALL have one clock and reset: clk in 1, rising-edge clock; reset in 1, asynchronous active-low.
REQ-004 branch_taken  in  1  predicated branch resolved taken in Execute.
REQ-005 pc_src_d  in  1  Decode instruction writes the PC.
REQ-006 pc_src_w  in  1  PC write retiring in Writeback.
REQ-007 mem_to_reg_e  in  1  Execute instruction is a load.
REQ-008 ra1_d, ra2_d  in  REG_ADDR_W  Decode source registers.
REQ-009 ra1_e, ra2_e, wa3_e  in  REG_ADDR_W  Execute sources/destination.
REQ-010 wa3_m, wa3_w  in  REG_ADDR_W; reg_write_m, reg_write_w  in  1  Memory/Writeback destination and predicated write enable.
REQ-011 stall_f, stall_d, flush_d, flush_e  out  1  pipeline control.
REQ-012 forward_a_e, forward_b_e  out  2  operand select: 00 register file, 01 Writeback result, 10 Memory ALU result.
REQ-013 branch_cnt, flush_cnt, stall_cnt  out  CNT_W  saturating event counters.

Function
REQ-014 FSM states: RUN, PC_WAIT.
REQ-015 RUN -> PC_WAIT when pc_src_d=1, no load-use stall, and branch_taken=0.
REQ-016 PC_WAIT -> RUN on pc_src_w=1 or branch_taken=1 (Decode PC writer squashed); branch_taken wins over simultaneous pc_src_d.
REQ-017 PC_WAIT: stall_f=1, flush_d=1; held until exit; 2-bit watchdog forces RUN after 3 cycles in PC_WAIT without pc_src_w.
REQ-018 Load-use stall = mem_to_reg_e & wa3_e≠0 & (wa3_e==ra1_d | wa3_e==ra2_d); gives stall_f=1, stall_d=1, flush_e=1, combinationally same cycle.
REQ-019 branch_taken=1: flush_d=1, flush_e=1, stall_f=0, stall_d=0, same cycle, overriding load-use stall and PC_WAIT.
REQ-020 forward_a_e=10 if reg_write_m & wa3_m==ra1_e; else 01 if reg_write_w & wa3_w==ra1_e; else 00; forward_b_e same using ra2_e; address 15 (PC) never forwarded.
REQ-021 branch_cnt increments on each cycle with branch_taken=1; flush_cnt on each cycle with flush_d or flush_e; stall_cnt on each cycle with stall_d=1.
REQ-022 Counters saturate at all-ones, never wrap; each updated with one-cycle latency (registered).
REQ-023 All control outputs are combinational from state and inputs; only FSM, watchdog and counters are registered.

Reset
REQ-024 reset=0 asynchronously forces state RUN, watchdog 0, all counters 0.
REQ-025 During reset: stall_f, stall_d, flush_d, flush_e = 0; forwarding follows REQ-020 combinationally.
REQ-026 Reset asserted mid-PC_WAIT aborts the wait; first cycle after release is RUN.

Structure
REQ-027 Shared package hazard_pkg SHALL hold fwd_sel_t (FWD_RF, FWD_WB, FWD_MEM), hz_state_t, REG_ADDR_W and CNT_W defaults.
REQ-028 SHALL instantiate sub-module sat_counter (parameter CNT_W; clk, reset, inc, count) three times.
REQ-029 Implementation SHALL be 120-400 lines total.

Verification
REQ-030 mem_to_reg_e=1, wa3_e=3, ra1_d=3 -> stall_f=stall_d=flush_e=1 that cycle; stall_cnt=1 next cycle.
REQ-031 pc_src_d=1 in RUN -> PC_WAIT; stall_f=flush_d=1 for 3 cycles; pc_src_w=1 on cycle 3 -> RUN next cycle.
REQ-032 branch_taken=1 together with load-use (wa3_e=2, ra2_d=2) -> flush_d=flush_e=1, stall_f=stall_d=0; branch_cnt=1.
REQ-033 reg_write_m=1, wa3_m=5 and reg_write_w=1, wa3_w=5, ra1_e=5 -> forward_a_e=10; same with ra1_e=wa3_m=wa3_w=15 -> 00.
REQ-034 CNT_W=4, 20 consecutive branch_taken cycles -> branch_cnt holds 15.
REQ-035 reset=0 for one cycle mid-PC_WAIT -> outputs drop immediately, counters 0, state RUN after release.
